mem_bus_ctrl: RTL and testbench

- Data-memory access controller sitting directly downstream of the mem_wb stage's memory-side outputs.
- Converts the single-cycle combinational read/write intent from mem_wb into a req/ack bus transaction.
- Sequences read-modify-write for byte/halfword stores: reads the word, returns it to mem_wb for merging, then writes the merged word.
- Stalls the pipeline until the access completes; a watchdog aborts hung accesses.

---
 rtl/mem_bus_ctrl_pkg.sv | 30 +++
 rtl/mem_bus_watchdog.sv | 27 ++
 rtl/mem_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared widths, access-size codes and controller state encoding for the
// data-memory bus controller.
package mem_bus_ctrl_pkg;

   localparam int MEM_ADDR_W  = 32;
   localparam int MEM_DATA_W  = 32;
   localparam int DATA_TYPE_W = 3;

   localparam logic [DATA_TYPE_W-1:0] DATATYPE_BYTE  = 3'd0;
   localparam logic [DATA_TYPE_W-1:0] DATATYPE_HALF  = 3'd1;
   localparam logic [DATA_TYPE_W-1:0] DATATYPE_WORD  = 3'd2;
   localparam logic [DATA_TYPE_W-1:0] DATATYPE_UBYTE = 3'd3;
   localparam logic [DATA_TYPE_W-1:0] DATATYPE_UHALF = 3'd4;

   localparam logic [MEM_DATA_W-1:0] DATA_ZERO = '0;

   typedef enum logic [2:0] {
      MC_IDLE   = 3'd0,
      MC_RD     = 3'd1,
      MC_WR     = 3'd2,
      MC_RMW_RD = 3'd3,
      MC_RMW_WR = 3'd4
   } mc_state_t;

   // Only signed sub-word codes need a read-modify-write; unsigned codes on a store act as word.
   function automatic logic is_subword(input logic [DATA_TYPE_W-1:0] dtype);
      return (dtype == DATATYPE_BYTE) || (dtype == DATATYPE_HALF);
   endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Counts bus cycles spent waiting for ack and flags the cycle in which the
// wait budget is used up.
module mem_bus_watchdog #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic timeout
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_reg <= '0;
      end else if (count_en) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   // Fires in the TIMEOUT_CYCLES-th consecutive waiting cycle.
   assign timeout = count_en && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Turns mem_wb's combinational load/store intent into req/ack bus phases,
// sequencing read-modify-write for sub-word stores and stalling until done.
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_enable_i,
   input  logic                   w_mem_enable_i,
   input  logic                   r_mem_enable_i,
   input  logic [MEM_ADDR_W-1:0]  w_mem_addr_i,
   input  logic [MEM_ADDR_W-1:0]  r_mem_addr_i,
   input  logic [MEM_DATA_W-1:0]  w_mem_data_i,
   input  logic [DATA_TYPE_W-1:0] data_type_i,
   output logic [MEM_DATA_W-1:0]  r_mem_data_o,
   output logic                   stall_o,
   output logic                   err_o,
   output logic                   bus_req_o,
   output logic                   bus_we_o,
   output logic [MEM_ADDR_W-1:0]  bus_addr_o,
   output logic [MEM_DATA_W-1:0]  bus_wdata_o,
   input  logic [MEM_DATA_W-1:0]  bus_rdata_i,
   input  logic                   bus_ack_i
);

   mc_state_t             state_reg, state_next;
   logic                  req_reg, req_next;
   logic                  we_reg, we_next;
   logic [MEM_ADDR_W-1:0] addr_reg, addr_next;
   logic [MEM_DATA_W-1:0] wdata_reg, wdata_next;
   logic [MEM_DATA_W-1:0] rdata_q_reg, rdata_q_next;
   logic                  ack_valid;
   logic                  timeout;

   // A stray ack while no request is outstanding must not advance anything.
   assign ack_valid = bus_ack_i && req_reg;

   mem_bus_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear    (!req_reg),
      .count_en (req_reg && !bus_ack_i),
      .timeout  (timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= MC_IDLE;
         req_reg     <= 1'b0;
         we_reg      <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         rdata_q_reg <= '0;
      end else begin
         state_reg   <= state_next;
         req_reg     <= req_next;
         we_reg      <= we_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         rdata_q_reg <= rdata_q_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      req_next     = req_reg;
      we_next      = we_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      rdata_q_next = rdata_q_reg;
      stall_o      = 1'b0;
      r_mem_data_o = rdata_q_reg;

      case (state_reg)
         MC_IDLE: begin
            if (mem_enable_i && (w_mem_enable_i || r_mem_enable_i)) begin
               stall_o  = 1'b1;
               req_next = 1'b1;
               if (w_mem_enable_i) begin
                  addr_next = w_mem_addr_i;
                  if (is_subword(data_type_i)) begin
                     state_next = MC_RMW_RD;
                     we_next    = 1'b0;
                  end else begin
                     state_next = MC_WR;
                     we_next    = 1'b1;
                     wdata_next = w_mem_data_i;
                  end
               end else begin
                  state_next = MC_RD;
                  we_next    = 1'b0;
                  addr_next  = r_mem_addr_i;
               end
            end
         end

         MC_RD, MC_RMW_RD: begin
            stall_o = 1'b1;
            if (ack_valid) begin
               r_mem_data_o = bus_rdata_i;
               rdata_q_next = bus_rdata_i;
               req_next     = 1'b0;
               if (state_reg == MC_RMW_RD) begin
                  // mem_wb has merged against bus_rdata_i this cycle.
                  state_next = MC_RMW_WR;
                  wdata_next = w_mem_data_i;
               end else begin
                  state_next = MC_IDLE;
                  stall_o    = 1'b0;
               end
            end else if (timeout) begin
               state_next   = MC_IDLE;
               req_next     = 1'b0;
               stall_o      = 1'b0;
               r_mem_data_o = DATA_ZERO;
            end
         end

         MC_WR, MC_RMW_WR: begin
            stall_o = 1'b1;
            if (!req_reg) begin
               // Gap cycle after the RMW read ack; launch the write phase.
               req_next  = 1'b1;
               we_next   = 1'b1;
               addr_next = w_mem_addr_i;
            end else if (ack_valid) begin
               state_next = MC_IDLE;
               req_next   = 1'b0;
               we_next    = 1'b0;
               stall_o    = 1'b0;
            end else if (timeout) begin
               state_next   = MC_IDLE;
               req_next     = 1'b0;
               we_next      = 1'b0;
               stall_o      = 1'b0;
               r_mem_data_o = DATA_ZERO;
            end
         end

         default: begin
            state_next = MC_IDLE;
            req_next   = 1'b0;
            we_next    = 1'b0;
         end
      endcase
   end

   assign err_o       = timeout;
   assign bus_req_o   = req_reg;
   assign bus_we_o    = we_reg;
   assign bus_addr_o  = addr_reg;
   assign bus_wdata_o = wdata_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: load, word store, sub-word RMW, watchdog
// abort, reset mid-access, store priority and unsigned-store-as-word.
module tb_mem_bus_ctrl;
   import mem_bus_ctrl_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   mem_enable;
   logic                   w_mem_enable;
   logic                   r_mem_enable;
   logic [MEM_ADDR_W-1:0]  w_mem_addr;
   logic [MEM_ADDR_W-1:0]  r_mem_addr;
   logic [MEM_DATA_W-1:0]  w_mem_data;
   logic [DATA_TYPE_W-1:0] data_type;
   logic [MEM_DATA_W-1:0]  r_mem_data;
   logic                   stall;
   logic                   err;
   logic                   bus_req;
   logic                   bus_we;
   logic [MEM_ADDR_W-1:0]  bus_addr;
   logic [MEM_DATA_W-1:0]  bus_wdata;
   logic [MEM_DATA_W-1:0]  bus_rdata;
   logic                   bus_ack;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_bus_ctrl #(
      .TIMEOUT_CYCLES (4),
      .CNT_W          (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_enable_i   (mem_enable),
      .w_mem_enable_i (w_mem_enable),
      .r_mem_enable_i (r_mem_enable),
      .w_mem_addr_i   (w_mem_addr),
      .r_mem_addr_i   (r_mem_addr),
      .w_mem_data_i   (w_mem_data),
      .data_type_i    (data_type),
      .r_mem_data_o   (r_mem_data),
      .stall_o        (stall),
      .err_o          (err),
      .bus_req_o      (bus_req),
      .bus_we_o       (bus_we),
      .bus_addr_o     (bus_addr),
      .bus_wdata_o    (bus_wdata),
      .bus_rdata_i    (bus_rdata),
      .bus_ack_i      (bus_ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-18s observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1; mem_enable = 1'b0; w_mem_enable = 1'b0; r_mem_enable = 1'b0;
      w_mem_addr = '0; r_mem_addr = '0; w_mem_data = '0; data_type = DATATYPE_WORD;
      bus_rdata = '0; bus_ack = 1'b0;
      tick(); tick();
      rst = 1'b0; #1;
      chk("rst_req", bus_req, 0);
      chk("rst_we", bus_we, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_wdata", bus_wdata, 0);
      chk("rst_err", err, 0);
      chk("rst_stall", stall, 0);
      chk("rst_rdata", r_mem_data, 0);

      // Load 0x100, ack in first request cycle
      tick();
      mem_enable = 1; r_mem_enable = 1; r_mem_addr = 32'h100; data_type = DATATYPE_WORD; #1;
      chk("ld_accept_stall", stall, 1);
      chk("ld_accept_req", bus_req, 0);
      tick();
      bus_ack = 1; bus_rdata = 32'hDEADBEEF; #1;
      chk("ld_req", bus_req, 1);
      chk("ld_addr", bus_addr, 32'h100);
      chk("ld_we", bus_we, 0);
      chk("ld_ack_rdata", r_mem_data, 32'hDEADBEEF);
      chk("ld_ack_stall", stall, 0);
      tick();
      bus_ack = 0; mem_enable = 0; r_mem_enable = 0; bus_rdata = '0; #1;
      chk("ld_done_req", bus_req, 0);
      chk("ld_held_rdata", r_mem_data, 32'hDEADBEEF);

      // Word store 0x200, ack in third request cycle
      tick();
      mem_enable = 1; w_mem_enable = 1; w_mem_addr = 32'h200; w_mem_data = 32'h12345678; #1;
      chk("st_accept_stall", stall, 1);
      tick(); #1;
      chk("st_req1", bus_req, 1);
      chk("st_we", bus_we, 1);
      chk("st_addr", bus_addr, 32'h200);
      chk("st_wdata", bus_wdata, 32'h12345678);
      chk("st_stall1", stall, 1);
      tick(); #1;
      chk("st_stall2", stall, 1);
      tick();
      bus_ack = 1; #1;
      chk("st_ack_stall", stall, 0);
      chk("st_ack_err", err, 0);
      tick();
      bus_ack = 0; mem_enable = 0; w_mem_enable = 0; #1;
      chk("st_done_req", bus_req, 0);
      chk("st_done_we", bus_we, 0);

      // Byte store 0x300 via read-modify-write
      tick();
      mem_enable = 1; w_mem_enable = 1; w_mem_addr = 32'h300; w_mem_data = 32'h00000011;
      data_type = DATATYPE_BYTE; #1;
      chk("rmw_accept_stall", stall, 1);
      tick();
      bus_ack = 1; bus_rdata = 32'hAABBCCDD; #1;
      chk("rmw_rd_req", bus_req, 1);
      chk("rmw_rd_we", bus_we, 0);
      chk("rmw_rd_addr", bus_addr, 32'h300);
      chk("rmw_rd_rdata", r_mem_data, 32'hAABBCCDD);
      chk("rmw_rd_stall", stall, 1);
      w_mem_data = 32'hAABBCC11;   // mem_wb merge of 0x11 into the read word
      tick();
      bus_ack = 0; bus_rdata = '0; #1;
      chk("rmw_gap_req", bus_req, 0);
      chk("rmw_gap_stall", stall, 1);
      chk("rmw_gap_rdata", r_mem_data, 32'hAABBCCDD);
      tick();
      bus_ack = 1; #1;
      chk("rmw_wr_req", bus_req, 1);
      chk("rmw_wr_we", bus_we, 1);
      chk("rmw_wr_addr", bus_addr, 32'h300);
      chk("rmw_wr_wdata", bus_wdata, 32'hAABBCC11);
      chk("rmw_wr_stall", stall, 0);
      tick();
      bus_ack = 0; mem_enable = 0; w_mem_enable = 0; data_type = DATATYPE_WORD; #1;
      chk("rmw_done_req", bus_req, 0);

      // Load 0x400 with no ack: watchdog aborts after 4 request cycles
      tick();
      mem_enable = 1; r_mem_enable = 1; r_mem_addr = 32'h400; #1;
      chk("to_accept_stall", stall, 1);
      for (int i = 1; i <= 3; i++) begin
         tick(); #1;
         chk("to_wait_req", bus_req, 1);
         chk("to_wait_err", err, 0);
         chk("to_wait_stall", stall, 1);
      end
      tick(); #1;
      chk("to_req4", bus_req, 1);
      chk("to_err", err, 1);
      chk("to_stall", stall, 0);
      chk("to_rdata_zero", r_mem_data, 0);
      tick();
      mem_enable = 0; r_mem_enable = 0; #1;
      chk("to_after_req", bus_req, 0);
      chk("to_after_err", err, 0);
      chk("to_after_rdata", r_mem_data, 32'hAABBCCDD);
      bus_ack = 1; bus_rdata = 32'h55555555; #1;
      chk("late_ack_rdata", r_mem_data, 32'hAABBCCDD);
      chk("late_ack_stall", stall, 0);
      tick();
      bus_ack = 0; bus_rdata = '0; #1;
      chk("late_ack_held", r_mem_data, 32'hAABBCCDD);
      chk("late_ack_req", bus_req, 0);

      // Reset during RMW_RD of a half store
      tick();
      mem_enable = 1; w_mem_enable = 1; w_mem_addr = 32'h500; w_mem_data = 32'h0000BEEF;
      data_type = DATATYPE_HALF; #1;
      chk("rr_accept_stall", stall, 1);
      tick(); #1;
      chk("rr_rd_req", bus_req, 1);
      rst = 1;
      tick();
      rst = 0; mem_enable = 0; w_mem_enable = 0; data_type = DATATYPE_WORD;
      bus_ack = 1; bus_rdata = 32'h99999999; #1;
      chk("rr_req", bus_req, 0);
      chk("rr_we", bus_we, 0);
      chk("rr_addr", bus_addr, 0);
      chk("rr_stall", stall, 0);
      tick();
      bus_ack = 0; bus_rdata = '0; #1;
      chk("rr_no_wr_req", bus_req, 0);
      chk("rr_no_wr_we", bus_we, 0);
      chk("rr_rdata", r_mem_data, 0);

      // Simultaneous read and write enable: store wins
      tick();
      mem_enable = 1; w_mem_enable = 1; r_mem_enable = 1; r_mem_addr = 32'h600;
      w_mem_addr = 32'h700; w_mem_data = 32'hCAFEF00D; #1;
      chk("both_accept_stall", stall, 1);
      tick();
      bus_ack = 1; #1;
      chk("both_we", bus_we, 1);
      chk("both_addr", bus_addr, 32'h700);
      chk("both_wdata", bus_wdata, 32'hCAFEF00D);
      chk("both_stall", stall, 0);
      tick();
      bus_ack = 0; mem_enable = 0; w_mem_enable = 0; r_mem_enable = 0; #1;
      chk("both_done_req", bus_req, 0);

      // Unsigned byte code on a store goes straight to a word write
      tick();
      mem_enable = 1; w_mem_enable = 1; w_mem_addr = 32'h800; w_mem_data = 32'h000000AB;
      data_type = DATATYPE_UBYTE; #1;
      tick();
      bus_ack = 1; #1;
      chk("ubyte_we", bus_we, 1);
      chk("ubyte_wdata", bus_wdata, 32'h000000AB);
      chk("ubyte_stall", stall, 0);
      tick();
      bus_ack = 0; mem_enable = 0; w_mem_enable = 0; #1;
      chk("ubyte_done_req", bus_req, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
